// File: rtl/food_placer.sv
// Food placer: draws random board cells until a free one is found, then reports it.
// Optional linear fallback scan is enabled by defining FOOD_LINEAR_FALLBACK_EN.
module food_placer #(
  parameter int MAX_TRIES = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       spawn_req_i,
  input  logic [5:0] rnd_i,
  input  logic       occ_hit_i,
  output logic [5:0] occ_addr_o,
  output logic [5:0] food_pos_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o
);

  typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, SCAN, DONE, FAIL} state_e;

  localparam logic [5:0] MaxTriesC = 6'(MAX_TRIES);

  state_e     state_q, state_d;
  logic [5:0] tries_q, tries_d;
  logic [5:0] cand_q, cand_d;
  logic [5:0] food_pos_q, food_pos_d;
`ifdef FOOD_LINEAR_FALLBACK_EN
  logic [5:0] scan_ptr_q, scan_ptr_d;
  logic [5:0] scan_cnt_q, scan_cnt_d;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tries_q    <= '0;
      cand_q     <= '0;
      food_pos_q <= '0;
`ifdef FOOD_LINEAR_FALLBACK_EN
      scan_ptr_q <= '0;
      scan_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      cand_q     <= cand_d;
      food_pos_q <= food_pos_d;
`ifdef FOOD_LINEAR_FALLBACK_EN
      scan_ptr_q <= scan_ptr_d;
      scan_cnt_q <= scan_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    cand_d     = cand_q;
    food_pos_d = food_pos_q;
    occ_addr_o = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    fail_o     = 1'b0;
`ifdef FOOD_LINEAR_FALLBACK_EN
    scan_ptr_d = scan_ptr_q;
    scan_cnt_d = scan_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (spawn_req_i) begin
          tries_d = '0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        busy_o  = 1'b1;
        cand_d  = rnd_i;
        tries_d = tries_q + 6'd1;
        state_d = CHECK;
      end
      CHECK: begin
        busy_o     = 1'b1;
        occ_addr_o = cand_q;
        if (!occ_hit_i) begin
          food_pos_d = cand_q;
          state_d    = DONE;
        end else if (tries_q < MaxTriesC) begin
          state_d = SAMPLE;
        end else begin
`ifdef FOOD_LINEAR_FALLBACK_EN
          scan_ptr_d = cand_q + 6'd1;
          scan_cnt_d = '0;
          state_d    = SCAN;
`else
          state_d = FAIL;
`endif
        end
      end
`ifdef FOOD_LINEAR_FALLBACK_EN
      // scan_cnt_q counts cells already rejected; the 64th rejection ends the scan
      SCAN: begin
        busy_o     = 1'b1;
        occ_addr_o = scan_ptr_q;
        if (!occ_hit_i) begin
          food_pos_d = scan_ptr_q;
          state_d    = DONE;
        end else if (scan_cnt_q == 6'd63) begin
          state_d = FAIL;
        end else begin
          scan_ptr_d = scan_ptr_q + 6'd1;
          scan_cnt_d = scan_cnt_q + 6'd1;
        end
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        fail_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign food_pos_o = food_pos_q;

endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: directed spawns push expected pulses, a monitor
// pops and compares whenever done or fail is seen.
module tb_food_placer;

  logic        clk;
  logic        reset;
  logic        spawn_req;
  logic [5:0]  rnd;
  logic        occ_hit;
  logic [5:0]  occ_addr;
  logic [5:0]  food_pos;
  logic        busy;
  logic        done;
  logic        fail;
  logic [63:0] occ_mask;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  typedef struct {
    bit         is_fail;
    logic [5:0] pos;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  food_placer #(.MAX_TRIES(3)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .spawn_req_i(spawn_req),
    .rnd_i      (rnd),
    .occ_hit_i  (occ_hit),
    .occ_addr_o (occ_addr),
    .food_pos_o (food_pos),
    .busy_o     (busy),
    .done_o     (done),
    .fail_o     (fail)
  );

  assign occ_hit = occ_mask[occ_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Monitor: every done/fail pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done || fail) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("[TB] FAIL unexpected_pulse: got done=%0b fail=%0b at cycle %0d, expected none",
                 done, fail, cyc);
      end else begin
        e = sbq.pop_front();
        checkOutput("pulse_kind", int'({done, fail}), e.is_fail ? 1 : 2);
        checkOutput("food_pos", int'(food_pos), int'(e.pos));
        checkOutput("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic applyStimulus(input bit exp_fail, input logic [5:0] exp_pos, input int lat);
    @(negedge clk);
    spawn_req = 1'b1;
    sbq.push_back('{exp_fail, exp_pos, cyc + lat});
    @(negedge clk);
    spawn_req = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", sbq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int k;
    int bad;
    reset     = 1'b1;
    spawn_req = 1'b1;
    rnd       = 6'd0;
    occ_mask  = '0;
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    spawn_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_occ_addr", int'(occ_addr), 0);
    checkOutput("rst_food_pos", int'(food_pos), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_fail", int'(fail), 0);

    $display("[TB] empty board, first-try placement");
    rnd = 6'd21;
    applyStimulus(1'b0, 6'd21, 3);
    checkOutput("busy_sample", int'(busy), 1);
    checkOutput("occ_addr_sample", int'(occ_addr), 0);
    @(negedge clk);
    checkOutput("busy_check", int'(busy), 1);
    checkOutput("occ_addr_check", int'(occ_addr), 21);
    @(negedge clk);
    checkOutput("busy_done", int'(busy), 0);
    checkOutput("occ_addr_done", int'(occ_addr), 0);
    waitDrain(50);
    checkOutput("food_pos_hold", int'(food_pos), 21);

    $display("[TB] one rejected draw");
    occ_mask = 64'd1 << 21;
    rnd      = 6'd21;
    applyStimulus(1'b0, 6'd40, 5);
    @(negedge clk);
    rnd = 6'd40;
    waitDrain(50);

    $display("[TB] full board, all draws rejected");
    occ_mask = '1;
    rnd      = 6'd10;
`ifdef FOOD_LINEAR_FALLBACK_EN
    applyStimulus(1'b1, 6'd40, 71);
    waitDrain(200);
`else
    applyStimulus(1'b1, 6'd40, 7);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (occ_addr != 6'd0 && occ_addr != 6'd10) bad++;
      @(negedge clk);
    end
    checkOutput("occ_addr_only_cand", bad, 0);
    waitDrain(50);
`endif
    checkOutput("food_pos_after_fail", int'(food_pos), 40);

    $display("[TB] only cell 63 free");
    occ_mask = ~(64'd1 << 63);
    rnd      = 6'd62;
`ifdef FOOD_LINEAR_FALLBACK_EN
    applyStimulus(1'b0, 6'd63, 8);
`else
    applyStimulus(1'b1, 6'd40, 7);
`endif
    waitDrain(200);

    $display("[TB] reset during a spawn");
    occ_mask = '0;
    rnd      = 6'd5;
    @(negedge clk);
    k = cyc;
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_elapsed", cyc - k, 3);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_occ_addr", int'(occ_addr), 0);
    checkOutput("abort_food_pos", int'(food_pos), 0);
    checkOutput("abort_done_fail", int'({done, fail}), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort_idle_busy", int'(busy), 0);

    $display("[TB] spawn held high while busy");
    occ_mask = 64'd1 << 7;
    rnd      = 6'd7;
    @(negedge clk);
    spawn_req = 1'b1;
    sbq.push_back('{1'b0, 6'd9, cyc + 5});
    @(negedge clk);
    @(negedge clk);
    rnd = 6'd9;
    @(negedge clk);
    spawn_req = 1'b0;
    waitDrain(50);
    repeat (10) @(negedge clk);
    checkOutput("no_queued_spawn_busy", int'(busy), 0);
    checkOutput("scoreboard_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
- REQ-001: Parameter MAX_TRIES, default 16, SHALL set the number of random draws per spawn; legal range 1..63.
- REQ-002: clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-003: reset  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
- REQ-004: spawn_req  input  1  request to place new food; SHALL be honoured only in IDLE.
- REQ-005: rnd  input  6  free-running value from the 6-bit XNOR LFSR; SHALL be sampled only in SAMPLE.
- REQ-006: occ_addr  output  6  board cell queried; row = occ_addr[5:3], col = occ_addr[2:0].
- REQ-007: occ_hit  input  1  combinational occupancy of occ_addr (1 = snake body); SHALL be valid in the same cycle.
- REQ-008: food_pos  output  6  registered position of the last placed food.
- REQ-009: busy  output  1  SHALL be high in SAMPLE, CHECK and SCAN.
- REQ-010: done  output  1  one-cycle pulse; food_pos is updated and valid.
- REQ-011: fail  output  1  one-cycle pulse; no free cell was found.

Function
- REQ-012: FSM states SHALL be IDLE, SAMPLE, CHECK, SCAN, DONE and FAIL.
- REQ-013: IDLE with spawn_req=1 SHALL go to SAMPLE and clear the try counter; otherwise it SHALL stay in IDLE.
- REQ-014: SAMPLE SHALL load cand <= rnd, increment tries, and go to CHECK.
- REQ-015: CHECK SHALL drive occ_addr=cand; occ_hit=0 SHALL load food_pos <= cand and go to DONE.
- REQ-016: CHECK with occ_hit=1 and tries<MAX_TRIES SHALL go to SAMPLE.
- REQ-017: CHECK with occ_hit=1 and tries==MAX_TRIES SHALL go to SCAN or FAIL, per REQ-027/028.
- REQ-018: First-try latency: spawn_req high at edge N SHALL give SAMPLE in cycle N+1, CHECK in N+2, and done=1 in N+3.
- REQ-019: Each rejected draw SHALL add 2 cycles of latency.
- REQ-020: SCAN SHALL load scan_ptr <= cand+1 mod 64 on entry and drive occ_addr=scan_ptr.
- REQ-021: SCAN with occ_hit=0 SHALL load food_pos <= scan_ptr and go to DONE.
- REQ-022: SCAN with occ_hit=1 SHALL increment scan_ptr, wrapping 63->0.
- REQ-023: SCAN SHALL go to FAIL after 64 cells have been checked.
- REQ-024: DONE and FAIL SHALL last exactly one cycle, then go to IDLE.
- REQ-025: spawn_req SHALL be ignored in all states except IDLE; no request is queued.
- REQ-026: occ_addr SHALL be 0 in IDLE, SAMPLE, DONE and FAIL; food_pos SHALL hold between updates.

Configuration
- REQ-027: With FOOD_LINEAR_FALLBACK_EN defined, the final rejected draw SHALL enter SCAN; cell 63, which the XNOR LFSR never produces, is reachable only this way.
- REQ-028: Without FOOD_LINEAR_FALLBACK_EN, the final rejected draw SHALL go directly to FAIL; SCAN logic SHALL be absent.

Reset
- REQ-029: Reset SHALL force IDLE, and set food_pos=0, occ_addr=0, busy=0, done=0, fail=0, tries=0, cand=0 and scan_ptr=0.
- REQ-030: Reset asserted in any state, including mid-SCAN, SHALL abort the request with no done or fail pulse.
- REQ-031: Reset SHALL take priority over spawn_req in the same cycle.

Verification
- REQ-032: Empty board, rnd=6'd21, spawn_req pulse at edge 0 -> done=1 in cycle 3, food_pos=21, busy high for cycles 1-2.
- REQ-033: occ_hit=1 for cand 21 only, rnd sequence 21 then 40 -> done=1 in cycle 5, food_pos=40.
- REQ-034: FOOD_LINEAR_FALLBACK_EN defined, MAX_TRIES=2, all cells occupied except 63, rnd fixed at 62 -> after 2 draws SCAN checks 63 -> done=1, food_pos=63.
- REQ-035: Same as REQ-034 with all 64 cells occupied -> 64 SCAN cycles, scan_ptr wraps 63->0, then fail=1 for one cycle and food_pos unchanged.
- REQ-036: FOOD_LINEAR_FALLBACK_EN undefined, MAX_TRIES=3, all cells occupied -> fail=1 in cycle 7, occ_addr never equals a non-cand value.
- REQ-037: Reset asserted in cycle 2 of a spawn -> IDLE next cycle, all outputs 0, no done or fail; a second spawn_req while busy -> ignored, exactly one done.
